oc8051_xdata_if: RTL and testbench
==================================

OC8051_XDATA_IF -- requirements
Module: oc8051_xdata_if

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum bus cycles to wait for ext_ack; legal range is 1..255.
REQ-002 The block SHALL run on one clock and a synchronous active-high reset: clk in 1, rising edge; rst in 1, synchronous, active-high.
REQ-003 The block SHALL have input dptr_hi, 8 bits: DPTR high byte from the DPTR register.
REQ-004 The block SHALL have input dptr_lo, 8 bits: DPTR low byte.
REQ-005 The block SHALL have input ri, 8 bits: the selected R0/R1 value, used for MOVX @Ri.
REQ-006 The block SHALL have input p2, 8 bits: the P2 latch, used as the high address byte for @Ri.
REQ-007 The block SHALL have input sel, 1 bit: 0 selects the DPTR address, 1 selects the {p2,ri} address.
REQ-008 The block SHALL have inputs rd and wr, 1 bit each: MOVX read and write requests, level, sampled only in IDLE.
REQ-009 The block SHALL have input wdat, 8 bits: write data (ACC).
REQ-010 The block SHALL have outputs rdat 8, stall 1, done 1 and err 1.
REQ-011 The block SHALL have outputs ext_addr 16, ext_dat_o 8, ext_we 1 and ext_stb 1.
REQ-012 The block SHALL have inputs ext_dat_i 8 and ext_ack 1.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUS and DONE.
REQ-014 In IDLE, when rd or wr is high at a clock edge, the block SHALL do all of the following at that edge:
- latch the address: sel=0 gives {dptr_hi,dptr_lo}; sel=1 gives {p2,ri};
- latch wdat;
- set ext_we to wr;
- go to BUS.
REQ-015 When rd and wr are both high in IDLE, the write SHALL take priority.
REQ-016 ext_addr, ext_dat_o and ext_we SHALL be registered and held constant from BUS entry until return to IDLE.
REQ-017 ext_stb SHALL be high in every BUS cycle and low in every other state.
REQ-018 In BUS, ext_ack high at an edge SHALL do the following:
- on a read, load rdat with ext_dat_i;
- go to DONE.
REQ-019 In DONE, done SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-020 Zero-wait latency: request sampled at edge N, ext_stb high in cycle N+1, ack sampled at edge N+1, done high in cycle N+2.
REQ-021 Each wait state (ext_ack low in a BUS cycle) SHALL add exactly one cycle to that latency.
REQ-022 stall SHALL be combinational and high in each of these cases:
- in IDLE while rd or wr is high;
- in all BUS cycles;
- never in DONE.
REQ-023 Timeout: an 8-bit counter SHALL clear on BUS entry and increment in each BUS cycle without ack.
REQ-024 When the counter reaches TIMEOUT-1 with ext_ack still low, the next edge SHALL do all of the following:
- go to DONE;
- drop ext_stb;
- on a read, load rdat with 8'hFF;
- assert err for the DONE cycle only.
REQ-025 When ext_ack arrives in the same cycle the timeout fires, the ack SHALL win: normal completion, err low.
REQ-026 rdat SHALL hold its value until the next read completes; write transactions SHALL NOT alter rdat.
REQ-027 rd and wr outside IDLE SHALL be ignored; they SHALL neither queue nor restart a transaction.
REQ-028 ext_ack in IDLE or DONE SHALL be ignored and SHALL have no effect on state or rdat.
REQ-029 Address wrap: no address arithmetic SHALL be performed; address 16'hFFFF SHALL be issued unchanged.

Reset
REQ-030 When rst is high at an edge, the following SHALL hold after that edge: state=IDLE, rdat=8'h00, ext_addr=16'h0000, ext_dat_o=8'h00, ext_we=0, ext_stb=0, done=0, err=0, counter=0.
REQ-031 rst SHALL take priority over every request and over ext_ack, including during BUS.
REQ-032 rst during BUS SHALL abort the transaction with ext_stb low after that edge and no done pulse.
REQ-033 stall SHALL be low while rst is high.

Verification
REQ-034 Zero-wait read: dptr=16'h1234, sel=0, rd pulse, ack in the first BUS cycle with ext_dat_i=8'h5A -> ext_addr=16'h1234, ext_we=0, one stb cycle, rdat=8'h5A, done in cycle N+2, err=0.
REQ-035 Write via Ri with waits: p2=8'hC0, ri=8'h07, sel=1, wdat=8'h3C, wr, ack after 3 wait cycles -> ext_addr=16'hC007, ext_dat_o=8'h3C, ext_we=1, stb high 4 cycles, rdat unchanged.
REQ-036 Timeout: TIMEOUT=4, read with ack never asserted -> stb high exactly 4 cycles, then done=1 and err=1 for one cycle, rdat=8'hFF.
REQ-037 Collisions: rd and wr high together -> write issued; ack at the timeout cycle -> normal completion, err=0; rd held high through BUS -> exactly one transaction, then a new one starts from IDLE.
REQ-038 Reset mid-BUS: rst at the second wait cycle -> stb low and all outputs at reset values after the edge, no done; a late ack is ignored.
REQ-039 Stray ack: ext_ack toggled in IDLE -> no state change, rdat unchanged, stall low.

Source files
------------

// File: rtl/oc8051_xdata_if.sv
// External data memory (MOVX) bus interface for the oc8051 core.
// Issues one strobed bus transaction per request and waits for ack, or gives up after TIMEOUT cycles.
module oc8051_xdata_if #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dptr_hi,
    input  logic [7:0]  dptr_lo,
    input  logic [7:0]  ri,
    input  logic [7:0]  p2,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  wdat,
    output logic [7:0]  rdat,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_dat_o,
    output logic        ext_we,
    output logic        ext_stb,
    input  logic [7:0]  ext_dat_i,
    input  logic        ext_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last unacknowledged BUS cycle before the transaction is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdat      <= '0;
            ext_addr  <= '0;
            ext_dat_o <= '0;
            ext_we    <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    err <= 1'b0;
                    if (rd || wr) begin
                        ext_addr  <= sel ? {p2, ri} : {dptr_hi, dptr_lo};
                        ext_dat_o <= wdat;
                        ext_we    <= wr;
                        cnt       <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so an ack on the timeout cycle completes normally.
                    if (ext_ack) begin
                        if (!ext_we)
                            rdat <= ext_dat_i;
                        state <= DONE;
                    end else if (cnt == TO_LAST) begin
                        if (!ext_we)
                            rdat <= 8'hFF;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ext_stb = (state == BUS);
    assign done    = (state == DONE);

    always_comb begin
        stall = 1'b0;
        if (!rst)
            stall = (state == BUS) || ((state == IDLE) && (rd || wr));
    end

endmodule

// File: tb/tb_oc8051_xdata_if.sv
// Bench for oc8051_xdata_if: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model.
module tb_oc8051_xdata_if;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dptr_hi, dptr_lo, ri, p2, wdat, ext_dat_i;
    logic        sel, rd, wr, ext_ack;
    logic [7:0]  rdat, ext_dat_o;
    logic        stall, done, err, ext_we, ext_stb;
    logic [15:0] ext_addr;

    int total = 0;
    int bad   = 0;

    oc8051_xdata_if #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .dptr_hi(dptr_hi), .dptr_lo(dptr_lo), .ri(ri), .p2(p2),
        .sel(sel), .rd(rd), .wr(wr), .wdat(wdat), .rdat(rdat), .stall(stall), .done(done),
        .err(err), .ext_addr(ext_addr), .ext_dat_o(ext_dat_o), .ext_we(ext_we),
        .ext_stb(ext_stb), .ext_dat_i(ext_dat_i), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: a transaction is "in flight" on the bus, counts its unanswered
    // cycles, and is followed by a single completion cycle.
    bit          started = 0;
    bit          m_inbus = 0, m_done = 0, m_err = 0, m_we = 0;
    int          m_waits = 0;
    logic [7:0]  m_rdat = 0, m_dout = 0;
    logic [15:0] m_addr = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_inbus = 0; m_done = 0; m_err = 0; m_we = 0;
            m_rdat = 0; m_dout = 0; m_addr = 0;
        end else if (m_done) begin
            m_done = 0; m_err = 0;
        end else if (m_inbus) begin
            if (ext_ack) begin
                m_inbus = 0; m_done = 1; m_err = 0;
                if (!m_we) m_rdat = ext_dat_i;
            end else if (m_waits + 1 == TO) begin
                m_inbus = 0; m_done = 1; m_err = 1;
                if (!m_we) m_rdat = 8'hFF;
            end else begin
                m_waits++;
            end
        end else if (rd || wr) begin
            m_inbus = 1; m_waits = 0;
            m_addr  = sel ? {p2, ri} : {dptr_hi, dptr_lo};
            m_dout  = wdat;
            m_we    = wr;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("stb",   16'(ext_stb),   16'(m_inbus));
            chk("done",  16'(done),      16'(m_done));
            chk("err",   16'(err),       16'(m_err));
            chk("stall", 16'(stall),     16'(!rst && (m_inbus || (!m_done && (rd || wr)))));
            chk("rdat",  16'(rdat),      16'(m_rdat));
            chk("addr",  ext_addr,       m_addr);
            chk("dout",  16'(ext_dat_o), 16'(m_dout));
            chk("we",    16'(ext_we),    16'(m_we));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int stb_n;

    initial begin
        rst = 1; rd = 1; wr = 0; sel = 0; ext_ack = 1;
        dptr_hi = 0; dptr_lo = 0; ri = 0; p2 = 0; wdat = 0; ext_dat_i = 8'hAA;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_rdat",  16'(rdat),  16'h0);
        chk("rst_stb",   16'(ext_stb), 16'h0);

        // Zero-wait read through DPTR
        rst = 0; rd = 1; ext_ack = 0; dptr_hi = 8'h12; dptr_lo = 8'h34; sel = 0;
        cyc();
        rd = 0; ext_ack = 1; ext_dat_i = 8'h5A;
        @(negedge clk);
        chk("zw_stb",  16'(ext_stb), 16'h1);
        chk("zw_addr", ext_addr,     16'h1234);
        chk("zw_we",   16'(ext_we),  16'h0);
        cyc();
        ext_ack = 0;
        @(negedge clk);
        chk("zw_done", 16'(done), 16'h1);
        chk("zw_err",  16'(err),  16'h0);
        chk("zw_rdat", 16'(rdat), 16'h5A);
        cyc();

        // Write via @Ri with three wait states
        p2 = 8'hC0; ri = 8'h07; sel = 1; wdat = 8'h3C; wr = 1;
        cyc();
        wr = 0; stb_n = 0;
        for (int i = 0; i < 4; i++) begin
            ext_ack = (i == 3);
            @(negedge clk);
            if (ext_stb) stb_n++;
            cyc();
        end
        ext_ack = 0;
        @(negedge clk);
        chk("wr_stbcnt", 16'(stb_n), 16'd4);
        chk("wr_addr",   ext_addr,   16'hC007);
        chk("wr_dout",   16'(ext_dat_o), 16'h3C);
        chk("wr_we",     16'(ext_we),  16'h1);
        chk("wr_done",   16'(done),    16'h1);
        chk("wr_rdat",   16'(rdat),    16'h5A);
        cyc();

        // Read that times out
        sel = 0; dptr_hi = 8'hFF; dptr_lo = 8'hFF; rd = 1;
        cyc();
        rd = 0; stb_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ext_stb) stb_n++;
            if (i == 4) begin
                chk("to_done", 16'(done), 16'h1);
                chk("to_err",  16'(err),  16'h1);
                chk("to_rdat", 16'(rdat), 16'hFF);
                chk("to_addr", ext_addr,  16'hFFFF);
            end
            cyc();
        end
        chk("to_stbcnt", 16'(stb_n), 16'd4);

        // rd+wr collision, ack on the timeout cycle, rd held high through the transaction
        rd = 1; wr = 1;
        cyc();
        wr = 0;
        for (int i = 0; i < 4; i++) begin
            ext_ack = (i == 3);
            @(negedge clk);
            if (i == 0) chk("col_we", 16'(ext_we), 16'h1);
            cyc();
        end
        ext_ack = 0;
        @(negedge clk);
        chk("col_done", 16'(done), 16'h1);
        chk("col_err",  16'(err),  16'h0);
        cyc();
        @(negedge clk);
        chk("col_idle_stb", 16'(ext_stb), 16'h0);
        chk("col_restall",  16'(stall),   16'h1);
        cyc();
        rd = 0; ext_ack = 1; ext_dat_i = 8'h81;
        @(negedge clk);
        chk("col_restart", 16'(ext_stb), 16'h1);
        cyc();
        ext_ack = 0;
        cyc();

        // Reset at the second wait cycle, then a late ack
        rd = 1;
        cyc();
        rd = 0;
        cyc();
        rst = 1;
        cyc();
        rst = 0; ext_ack = 1;
        @(negedge clk);
        chk("rb_stb",  16'(ext_stb), 16'h0);
        chk("rb_addr", ext_addr,     16'h0);
        chk("rb_done", 16'(done),    16'h0);
        cyc();
        @(negedge clk);
        chk("rb_late_done", 16'(done), 16'h0);
        chk("rb_rdat",      16'(rdat), 16'h0);

        // Stray acks in IDLE
        for (int i = 0; i < 4; i++) begin
            ext_ack = i[0]; ext_dat_i = 8'h77;
            cyc();
        end
        @(negedge clk);
        chk("stray_rdat",  16'(rdat),  16'h0);
        chk("stray_stall", 16'(stall), 16'h0);
        ext_ack = 0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(63) == 0);
            rd        = ($urandom_range(3) == 0);
            wr        = ($urandom_range(3) == 0);
            sel       = $urandom_range(1);
            ext_ack   = ($urandom_range(2) == 0);
            dptr_hi   = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
            dptr_lo   = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
            ri        = 8'($urandom);
            p2        = 8'($urandom);
            wdat      = 8'($urandom);
            ext_dat_i = 8'($urandom);
            cyc();
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
